// File: rtl/sram_access_ctrl_if.sv
// rtl/sram_access_ctrl_if.sv - core-side command/read-return bundle for sram_access_ctrl
//
// Purpose: groups the core-facing command handshake and read-return signals.
//   cmd_valid/cmd_ready : command handshake (accept when both high at a clk edge)
//   cmd_we              : 1 = write, 0 = read
//   cmd_addr/cmd_wdata  : word address and write data
//   rd_valid/rd_data    : one-cycle read-result strobe and last captured word
//   busy                : sequencer is not idle
// Modports: master = core side, slave = sequencer side.

interface sram_access_ctrl_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              busy;

    modport master (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        input  cmd_ready, rd_valid, rd_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata,
        output cmd_ready, rd_valid, rd_data, busy
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// rtl/sram_access_ctrl.sv - single-word command sequencer for an async SRAM pin wrapper
//
// Purpose: turns one read/write command at a time into a timed asynchronous-SRAM
//   cycle: address/data setup before WE, a WE_CYCLES-long WE pulse, one hold cycle,
//   or a READ_WAIT-cycle read access followed by a one-cycle rd_valid strobe.
// Ports:
//   clk             system clock, all state on rising edge
//   reset           asynchronous active-high reset
//   bus             core-side command / read-return bundle (slave modport)
//   mem_address     address to SRAM wrapper
//   mem_wren        write enable to SRAM wrapper (high only during the WE pulse)
//   mem_data_write  write data to SRAM wrapper
//   mem_data_read   read data from SRAM wrapper

module sram_access_ctrl #(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 32,
    parameter int READ_WAIT = 2,
    parameter int WE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_access_ctrl_if.slave    bus,
    output logic [ADDR_W-1:0]    mem_address,
    output logic                 mem_wren,
    output logic [DATA_W-1:0]    mem_data_write,
    input  logic [DATA_W-1:0]    mem_data_read
);

    if (READ_WAIT < 1 || WE_CYCLES < 1) begin : g_param_check
        $error("sram_access_ctrl: READ_WAIT and WE_CYCLES must both be >= 1");
    end

    // One shared counter serves both the WE pulse and the read wait.
    localparam int CNT_MAX = (READ_WAIT > WE_CYCLES) ? READ_WAIT : WE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_PULSE,
        W_HOLD,
        R_WAIT
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              mem_wren_q, mem_wren_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_write_q, mem_data_write_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            cmd_ready_q      <= 1'b0;
            mem_wren_q       <= 1'b0;
            rd_valid_q       <= 1'b0;
            rd_data_q        <= '0;
            mem_address_q    <= '0;
            mem_data_write_q <= '0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            cmd_ready_q      <= cmd_ready_d;
            mem_wren_q       <= mem_wren_d;
            rd_valid_q       <= rd_valid_d;
            rd_data_q        <= rd_data_d;
            mem_address_q    <= mem_address_d;
            mem_data_write_q <= mem_data_write_d;
            busy_q           <= busy_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        cmd_ready_d      = cmd_ready_q;
        mem_wren_d       = 1'b0;
        rd_valid_d       = 1'b0;
        rd_data_d        = rd_data_q;
        mem_address_d    = mem_address_q;
        mem_data_write_d = mem_data_write_q;

        case (state_q)
            IDLE: begin
                // cmd_ready_q is 0 only in the first cycle after reset, so the
                // first edge after release just raises ready without accepting.
                cmd_ready_d = 1'b1;
                if (bus.cmd_valid && cmd_ready_q) begin
                    mem_address_d    = bus.cmd_addr;
                    mem_data_write_d = bus.cmd_wdata;
                    cmd_ready_d      = 1'b0;
                    cnt_d            = '0;
                    state_d          = bus.cmd_we ? W_SETUP : R_WAIT;
                end
            end
            W_SETUP: begin
                mem_wren_d = 1'b1;
                cnt_d      = '0;
                state_d    = W_PULSE;
            end
            W_PULSE: begin
                if (cnt_q == WE_LAST) begin
                    state_d = W_HOLD;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    mem_wren_d = 1'b1;
                end
            end
            W_HOLD: begin
                cmd_ready_d = 1'b1;
                state_d     = IDLE;
            end
            R_WAIT: begin
                if (cnt_q == RD_LAST) begin
                    rd_data_d   = mem_data_read;
                    rd_valid_d  = 1'b1;
                    cmd_ready_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_data_q;
    assign bus.busy       = busy_q;
    assign mem_address    = mem_address_q;
    assign mem_wren       = mem_wren_q;
    assign mem_data_write = mem_data_write_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb/tb_sram_access_ctrl.sv - scoreboard bench for sram_access_ctrl (default and READ_WAIT=4/WE_CYCLES=1 instances)

module tb_sram_access_ctrl;

    localparam int AW = 18;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0]         cvalid_v, cwe_v;
    logic [1:0][AW-1:0] caddr_v;
    logic [1:0][DW-1:0] cwdata_v;
    logic [1:0]         ready_v, rdv_v, busy_v, wren_v;
    logic [1:0][DW-1:0] rdd_v, mwd_v, mrd_v;
    logic [1:0][AW-1:0] maddr_v;

    sram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) if0 ();
    sram_access_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) if1 ();

    sram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave),
        .mem_address(maddr_v[0]), .mem_wren(wren_v[0]),
        .mem_data_write(mwd_v[0]), .mem_data_read(mrd_v[0])
    );

    sram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_WAIT(4), .WE_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave),
        .mem_address(maddr_v[1]), .mem_wren(wren_v[1]),
        .mem_data_write(mwd_v[1]), .mem_data_read(mrd_v[1])
    );

    assign if0.cmd_valid = cvalid_v[0];
    assign if0.cmd_we    = cwe_v[0];
    assign if0.cmd_addr  = caddr_v[0];
    assign if0.cmd_wdata = cwdata_v[0];
    assign ready_v[0]    = if0.cmd_ready;
    assign rdv_v[0]      = if0.rd_valid;
    assign rdd_v[0]      = if0.rd_data;
    assign busy_v[0]     = if0.busy;

    assign if1.cmd_valid = cvalid_v[1];
    assign if1.cmd_we    = cwe_v[1];
    assign if1.cmd_addr  = caddr_v[1];
    assign if1.cmd_wdata = cwdata_v[1];
    assign ready_v[1]    = if1.cmd_ready;
    assign rdv_v[1]      = if1.rd_valid;
    assign rdd_v[1]      = if1.rd_data;
    assign busy_v[1]     = if1.busy;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } sb_t;

    sb_t           sb_q[$];
    logic [DW-1:0] ref_mem[int];
    logic [DW-1:0] sram[int];
    logic [DW-1:0] last_rd[2];

    logic [1:0]         prev_wren = '0;
    logic [1:0]         prev_rdv = '0;
    int                 plen[2];
    logic [1:0][AW-1:0] prev_addr;
    logic [1:0][DW-1:0] prev_wd;
    sb_t                mon_e;

    function automatic int we_cyc(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int rd_wait(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic int key(input int k, input logic [AW-1:0] a);
        return k * (1 << 20) + int'(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // SRAM model plus output monitor; everything sampled on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wren_v[k]) sram[key(k, maddr_v[k])] = mwd_v[k];
            if (sram.exists(key(k, maddr_v[k]))) mrd_v[k] = sram[key(k, maddr_v[k])];
            else mrd_v[k] = '0;

            if (reset) begin
                prev_wren[k] = 1'b0;
                prev_rdv[k]  = 1'b0;
                plen[k]      = 0;
            end else begin
                if (wren_v[k] || prev_wren[k]) begin
                    chk("addr_stable", maddr_v[k], prev_addr[k]);
                    chk("wdata_stable", mwd_v[k], prev_wd[k]);
                end
                if (wren_v[k]) plen[k]++;
                if (!wren_v[k] && prev_wren[k]) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_empty_wr", 1, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("sb_kind_wr", mon_e.we, 1);
                        chk("wr_addr", maddr_v[k], mon_e.addr);
                        chk("wr_data", mwd_v[k], mon_e.data);
                        chk("wr_pulse_len", plen[k], we_cyc(k));
                    end
                    plen[k] = 0;
                end
                if (rdv_v[k]) begin
                    chk("rdv_single", prev_rdv[k], 0);
                    if (sb_q.size() == 0) begin
                        chk("sb_empty_rd", 1, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("sb_kind_rd", mon_e.we, 0);
                        chk("rd_data", rdd_v[k], mon_e.data);
                    end
                end
                prev_wren[k] = wren_v[k];
                prev_rdv[k]  = rdv_v[k];
            end
            prev_addr[k] = maddr_v[k];
            prev_wd[k]   = mwd_v[k];
        end
    end

    // Drives one command on instance k and waits for acceptance. With measure set,
    // also follows the cycle to completion and returns on the falling edge where
    // cmd_ready is high again; otherwise returns just after the accept edge.
    task automatic issue(input int k, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input bit keep, input bit measure);
        sb_t e;
        int  t;
        int  n;
        int  kk;
        bit  done;
        kk = key(k, addr);
        cwe_v[k]    = we;
        caddr_v[k]  = addr;
        cwdata_v[k] = data;
        cvalid_v[k] = 1'b1;
        e.we   = we;
        e.addr = addr;
        if (we) begin
            ref_mem[kk] = data;
            e.data      = data;
        end else begin
            e.data     = ref_mem.exists(kk) ? ref_mem[kk] : '0;
            last_rd[k] = e.data;
        end
        sb_q.push_back(e);
        t = 0;
        while (!ready_v[k] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("tmo_accept", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) cvalid_v[k] = 1'b0;
        if (measure) begin
            n    = 0;
            done = 1'b0;
            while (!done) begin
                @(negedge clk);
                if (ready_v[k]) begin
                    done = 1'b1;
                end else if (n >= 50) begin
                    chk("tmo_ready", 0, 1);
                    done = 1'b1;
                end else begin
                    n++;
                    chk("busy_active", busy_v[k], 1);
                    if (we) begin
                        chk("wren_seq", wren_v[k], (n >= 2 && n <= we_cyc(k) + 1));
                        chk("wr_addr_pins", maddr_v[k], addr);
                        chk("wr_data_pins", mwd_v[k], data);
                    end else begin
                        chk("wren_rd", wren_v[k], 0);
                    end
                end
            end
            chk(we ? "rdy_low_wr" : "rdy_low_rd", n, we ? we_cyc(k) + 2 : rd_wait(k));
            chk("busy_idle", busy_v[k], 0);
            if (!we) chk("rdv_with_rdy", rdv_v[k], 1);
        end
    endtask

    task automatic run_basic(input int k);
        issue(k, 1'b1, 18'h00012, 32'hDEADBEEF, 1'b0, 1'b1);
        chk("rd_hold_wr", rdd_v[k], last_rd[k]);
        sram[key(k, 18'h00012)]    = 32'hCAFEF00D;
        ref_mem[key(k, 18'h00012)] = 32'hCAFEF00D;
        issue(k, 1'b0, 18'h00012, '0, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("rdv_after", rdv_v[k], 0);
            chk("rd_data_hold", rdd_v[k], 32'hCAFEF00D);
        end
        issue(k, 1'b1, 18'h3FFFF, 32'h12345678, 1'b1, 1'b1);
        chk("valid_held", cvalid_v[k], 1);
        issue(k, 1'b0, 18'h3FFFF, '0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        chk("rd_b2b_hold", rdd_v[k], 32'h12345678);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        cvalid_v   = '0;
        cwe_v      = '0;
        caddr_v    = '0;
        cwdata_v   = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;

        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", ready_v[k], 0);
            chk("rst_wren", wren_v[k], 0);
            chk("rst_rdv", rdv_v[k], 0);
            chk("rst_rd_data", rdd_v[k], 0);
            chk("rst_addr", maddr_v[k], 0);
            chk("rst_wdata", mwd_v[k], 0);
            chk("rst_busy", busy_v[k], 0);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rdy_pre_edge", ready_v[0], 0);
        @(posedge clk);
        #1;
        chk("rdy_after_rel0", ready_v[0], 1);
        chk("rdy_after_rel1", ready_v[1], 1);

        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", ready_v[0], 0);
        chk("mid_rst_wren", wren_v[0], 0);
        chk("mid_rst_rdv", rdv_v[0], 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rdy_pre_edge2", ready_v[0], 0);
        @(posedge clk);
        #1;
        chk("rdy_after_rel2", ready_v[0], 1);

        run_basic(0);

        issue(0, 1'b1, 18'h00ABC, 32'h55AA55AA, 1'b0, 1'b0);
        begin
            int t;
            t = 0;
            while (!wren_v[0] && t < 10) begin
                @(negedge clk);
                t++;
            end
            if (t >= 10) chk("tmo_wren", 0, 1);
        end
        #2;
        reset = 1'b1;
        #1;
        chk("wren_async_drop", wren_v[0], 0);
        chk("abort_rdv", rdv_v[0], 0);
        chk("abort_ready", ready_v[0], 0);
        chk("abort_busy", busy_v[0], 0);
        sb_q.delete();
        last_rd[0] = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        reset = 1'b0;
        issue(0, 1'b0, 18'h3FFFF, '0, 1'b0, 1'b1);
        chk("post_rst_rd", rdd_v[0], 32'h12345678);

        run_basic(1);

        repeat (4) @(negedge clk);
        chk("sb_left", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
